// File: rtl/pdm_modulator.sv
// pdm_modulator: turns signed PCM at pdm_clk/R into a 1-bit PDM stream (zero-order hold + 2nd-order sigma-delta).
// Latency: a sample popped at a boundary edge drives the integrators in the next cycle; pdm_out is registered.
// Backpressure: din_ready drops while the input FIFO is full; an empty FIFO at a boundary plays silence and sets sticky underrun.
module pdm_modulator #(
  parameter int R          = 24,
  parameter int IN_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               pdm_clk,
  input  logic                               reset_n,
  input  logic signed [IN_WIDTH-1:0]         din,
  input  logic                               din_valid,
  output logic                               din_ready,
  input  logic                               clear_underrun,
  output logic                               pdm_out,
  output logic                               sample_tick,
  output logic                               underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = (R > 1) ? $clog2(R) : 1;
  // Integrators carry 6 guard bits over the sample; sums get 2 more before clamping.
  localparam int IW = IN_WIDTH + 6;
  localparam int SW = IW + 2;

  localparam logic signed [SW-1:0] F_POS = SW'(64'sd1 <<< (IN_WIDTH - 1));
  localparam logic signed [SW-1:0] I_MAX = {{(SW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [SW-1:0] I_MIN = {{(SW-IW+1){1'b1}}, {(IW-1){1'b0}}};
  localparam logic [PW-1:0]        PHASE_LAST = PW'(R - 1);
  localparam logic [LW-1:0]        LEVEL_FULL = LW'(FIFO_DEPTH);

  logic signed [IN_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic [PW-1:0]              phase_q, phase_d;
  logic signed [IN_WIDTH-1:0] x_q, x_d;
  logic signed [IW-1:0]       i1_q, i1_d;
  logic signed [IW-1:0]       i2_q, i2_d;
  logic                       pdm_q, pdm_d;
  logic                       tick_q, tick_d;
  logic                       under_q, under_d;

  logic                       push, pop, boundary, fifo_empty;
  logic signed [SW-1:0]       fb, sum1, sum2;

  // Clamp a widened sum back into integrator range instead of wrapping.
  function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [IW-1:0] r;
    if (v > I_MAX)      r = I_MAX[IW-1:0];
    else if (v < I_MIN) r = I_MIN[IW-1:0];
    else                r = v[IW-1:0];
    return r;
  endfunction

  assign din_ready   = (level_q < LEVEL_FULL);
  assign fifo_level  = level_q;
  assign pdm_out     = pdm_q;
  assign sample_tick = tick_q;
  assign underrun    = under_q;

  // Next-state: FIFO bookkeeping, sample hold, sigma-delta loop and underrun flag.
  always_comb begin
    boundary   = (phase_q == PHASE_LAST);
    fifo_empty = (level_q == '0);
    push       = din_valid && din_ready;
    // Pop only what was already stored: a word pushed on this edge cannot fall through.
    pop        = boundary && !fifo_empty;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    phase_d = boundary ? '0 : phase_q + PW'(1);

    x_d = x_q;
    if (boundary) x_d = fifo_empty ? '0 : mem_q[rd_ptr_q];

    // Loop uses the held x and last output bit as feedback.
    fb   = pdm_q ? F_POS : -F_POS;
    sum1 = {{(SW-IW){i1_q[IW-1]}}, i1_q} + {{(SW-IN_WIDTH){x_q[IN_WIDTH-1]}}, x_q} - fb;
    i1_d = sat(sum1);
    sum2 = {{(SW-IW){i2_q[IW-1]}}, i2_q} + {{(SW-IW){i1_d[IW-1]}}, i1_d} - fb;
    i2_d = sat(sum2);
    pdm_d = ~i2_d[IW-1];

    tick_d = boundary;

    // A fresh underrun beats a simultaneous clear.
    if (boundary && fifo_empty) under_d = 1'b1;
    else if (clear_underrun)    under_d = 1'b0;
    else                        under_d = under_q;
  end

  // FIFO storage; contents are don't-care while the level says empty.
  always_ff @(posedge pdm_clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge pdm_clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      phase_q  <= '0;
      x_q      <= '0;
      i1_q     <= '0;
      i2_q     <= '0;
      pdm_q    <= 1'b0;
      tick_q   <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      phase_q  <= phase_d;
      x_q      <= x_d;
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      pdm_q    <= pdm_d;
      tick_q   <= tick_d;
      under_q  <= under_d;
    end
  end

endmodule

// File: tb/tb_pdm_modulator.sv
// tb_pdm_modulator: drives pdm_modulator with directed and random PCM and compares every cycle to a queue-based model.
// Outputs sampled on the falling edge; inputs driven there too.
// Density windows check the long-run ones ratio; directed cases cover stall, underrun and reset.
module tb_pdm_modulator;
  localparam int R  = 24;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);
  localparam longint F    = 64'sd32768;
  localparam longint IMAX = (64'sd1 <<< 21) - 1;
  localparam longint IMIN = -(64'sd1 <<< 21);

  logic                pdm_clk = 1'b0;
  logic                reset_n = 1'b0;
  logic signed [W-1:0] din = '0;
  logic                din_valid = 1'b0;
  logic                clear_underrun = 1'b0;
  logic                din_ready, pdm_out, sample_tick, underrun;
  logic [LW-1:0]       fifo_level;

  int n_checks = 0;
  int n_errors = 0;
  int ones, ticks;

  // Reference state: FIFO as a queue, integrators as plain integers.
  int     m_q[$];
  int     m_phase = 0;
  longint m_x = 0, m_i1 = 0, m_i2 = 0;
  bit     m_pdm = 0, m_tick = 0, m_under = 0;

  always #5 pdm_clk = ~pdm_clk;

  pdm_modulator #(.R(R), .IN_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .pdm_clk        (pdm_clk),
    .reset_n        (reset_n),
    .din            (din),
    .din_valid      (din_valid),
    .din_ready      (din_ready),
    .clear_underrun (clear_underrun),
    .pdm_out        (pdm_out),
    .sample_tick    (sample_tick),
    .underrun       (underrun),
    .fifo_level     (fifo_level)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > IMAX) return IMAX;
    if (v < IMIN) return IMIN;
    return v;
  endfunction

  // One clock edge of the reference, using the inputs presented at that edge.
  task automatic model_edge();
    longint fb, a, b;
    bit bnd, empty, psh;
    if (!reset_n) begin
      m_q.delete();
      m_phase = 0; m_x = 0; m_i1 = 0; m_i2 = 0;
      m_pdm = 0; m_tick = 0; m_under = 0;
      return;
    end
    bnd   = (m_phase == R - 1);
    empty = (m_q.size() == 0);
    psh   = din_valid && (m_q.size() < D);
    fb    = m_pdm ? F : -F;
    a     = clamp(m_i1 + m_x - fb);
    b     = clamp(m_i2 + a - fb);
    m_i1  = a;
    m_i2  = b;
    m_pdm = (b >= 0);
    if (bnd) begin
      if (empty) begin
        m_x = 0;
        m_under = 1;
      end else begin
        m_x = m_q.pop_front();
      end
    end
    if (!(bnd && empty) && clear_underrun) m_under = 0;
    if (psh) m_q.push_back(int'(din));
    m_tick  = bnd;
    m_phase = (m_phase + 1) % R;
  endtask

  task automatic step();
    @(posedge pdm_clk);
    model_edge();
    @(negedge pdm_clk);
    check("pdm_out", pdm_out, m_pdm);
    check("sample_tick", sample_tick, m_tick);
    check("underrun", underrun, m_under);
    check("fifo_level", fifo_level, m_q.size());
    check("din_ready", din_ready, (m_q.size() < D));
    ones  += int'(pdm_out);
    ticks += int'(sample_tick);
  endtask

  task automatic run(input int n, input bit v, input longint val);
    logic signed [63:0] tmp;
    tmp = val;
    for (int k = 0; k < n; k++) begin
      din_valid = v;
      din       = tmp[W-1:0];
      step();
    end
  endtask

  task automatic density(input string tag, input int n, input int target, input int tol,
                         input bit v, input longint val);
    ones = 0;
    run(n, v, val);
    check(tag, (ones >= target - tol && ones <= target + tol) ? target : ones, target);
  endtask

  // Step until the current cycle is the last of a sample period.
  task automatic wait_last();
    for (int k = 0; k < 2 * R && m_phase != R - 1; k++) step();
  endtask

  initial begin
    logic signed [W-1:0] vals [5];
    bit acc;
    int stalls;

    // Reset held for a few edges.
    reset_n = 1'b0;
    repeat (3) step();
    check("rst_pdm", pdm_out, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_under", underrun, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", din_ready, 1);
    reset_n = 1'b1;

    // Idle after reset: silence, first boundary at cycle R.
    ones = 0; ticks = 0;
    run(R - 1, 0, 0);
    check("under_before_first", underrun, 0);
    run(1, 0, 0);
    check("under_first", underrun, 1);
    check("tick_first", sample_tick, 1);
    run(2400 - R, 0, 0);
    check("idle_ticks", ticks, 2400 / R);
    check("idle_density", (ones >= 1188 && ones <= 1212) ? 1200 : ones, 1200);

    // Back-to-back burst into an empty FIFO right after a boundary.
    clear_underrun = 1'b1; step(); clear_underrun = 1'b0;
    check("clear_idle", underrun, 0);
    for (int k = 0; k < 2 * R && !sample_tick; k++) step();
    vals[0] = 16'sd12000; vals[1] = -16'sd9000; vals[2] = 16'sd26000;
    vals[3] = -16'sd26000; vals[4] = 16'sd777;
    for (int k = 0; k < 5; k++) begin
      din = vals[k];
      din_valid = 1'b1;
      acc = 1'b0;
      stalls = 0;
      for (int t = 0; t < 3 * R && !acc; t++) begin
        acc = din_ready;
        if (!acc) stalls++;
        step();
      end
      check("burst_accept", acc, 1);
      if (k == 3) begin
        check("burst_full_level", fifo_level, D);
        check("burst_full_ready", din_ready, 0);
      end
      if (k == 4) check("burst_fifth_stalled", (stalls > 0), 1);
    end
    din_valid = 1'b0;
    run(6 * R, 0, 0);

    // Constant half-scale streams.
    run(240, 1, 16384);
    clear_underrun = 1'b1; din_valid = 1'b1; step(); clear_underrun = 1'b0;
    density("density_pos_half", 4800, 3600, 24, 1, 16384);
    check("under_pos_half", underrun, 0);
    run(240, 1, -16384);
    density("density_neg_half", 4800, 1200, 24, 1, -16384);
    check("under_neg_half", underrun, 0);

    // Full-scale stress, then recovery at zero.
    run(480, 1, 32767);
    density("fullscale_pos", 1920, 1920, 19, 1, 32767);
    run(480, 1, -32768);
    density("fullscale_neg", 1920, 0, 19, 1, -32768);
    run(480, 1, 0);
    density("recovery_zero", 2400, 1200, 24, 1, 0);

    // Random samples, random valid, occasional clears.
    for (int k = 0; k < 4000; k++) begin
      din            = W'(int'($urandom_range(0, 52428)) - 26214);
      din_valid      = ($urandom_range(0, 9) < 7);
      clear_underrun = ($urandom_range(0, 19) == 0);
      step();
    end
    clear_underrun = 1'b0;
    din_valid = 1'b0;

    // Push landing on a boundary with the FIFO empty: no fall-through.
    run(6 * R, 0, 0);
    for (int k = 0; k < 2 * R && !sample_tick; k++) step();
    clear_underrun = 1'b1; step(); clear_underrun = 1'b0;
    check("clear_before_edge_push", underrun, 0);
    wait_last();
    din = 16'sd1234; din_valid = 1'b1; step(); din_valid = 1'b0;
    check("edge_push_under", underrun, 1);
    check("edge_push_level", fifo_level, 1);
    wait_last();
    step();
    check("edge_push_popped", fifo_level, 0);
    clear_underrun = 1'b1; step(); clear_underrun = 1'b0;
    check("clear_midperiod", underrun, 0);
    wait_last();
    clear_underrun = 1'b1; step(); clear_underrun = 1'b0;
    check("set_beats_clear", underrun, 1);

    // Reset in the middle of a stream.
    run(100, 1, 5000);
    din_valid = 1'b1;
    reset_n = 1'b0; step(); reset_n = 1'b1;
    din_valid = 1'b0;
    check("midrst_pdm", pdm_out, 0);
    check("midrst_tick", sample_tick, 0);
    check("midrst_under", underrun, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_ready", din_ready, 1);
    run(3 * R, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
